id_operand_stage: RTL and testbench

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

---
 rtl/id_operand_stage_pkg.sv | 12 +
 rtl/id_operand_stage_fwd_select.sv | 39 +++
 rtl/id_operand_stage.sv | 117 +++++++++++
 tb/tb_id_operand_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
// Shared defaults and field positions for the decode-stage operand
// fetch/bypass block.
package id_operand_stage_pkg;
    localparam int XLEN_DEF       = 32;
    localparam int NREG_DEF       = 32;
    localparam int NFWD_DEF       = 3;
    localparam int PAYLOAD_WD_DEF = 64;

    // Bit positions inside the 2-bit read-enable field.
    localparam int RD_EN_RS = 0;
    localparam int RD_EN_RT = 1;
endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// Per-operand bypass selection: the youngest matching source wins, and its
// readiness decides whether the operand can be consumed this cycle.
module fwd_select
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = 5,
    parameter int NFWD = NFWD_DEF
) (
    input  logic                 i_used,
    input  logic [AW-1:0]        i_addr,
    input  logic [NFWD-1:0]      i_fwd_valid,
    input  logic [NFWD*AW-1:0]   i_fwd_dest,
    input  logic [NFWD*XLEN-1:0] i_fwd_data,
    input  logic [NFWD-1:0]      i_fwd_ready,
    input  logic [XLEN-1:0]      i_rf_data,
    output logic [XLEN-1:0]      o_value,
    output logic                 o_not_ready
);

    logic w_hit;

    // Scanning upward and latching the first hit gives index 0 priority;
    // older matches behind a hit are shadowed even when they are ready.
    always_comb begin
        o_value     = i_rf_data;
        o_not_ready = 1'b0;
        w_hit       = 1'b0;
        for (int i = 0; i < NFWD; i++) begin
            if (i_used && !w_hit && i_fwd_valid[i] &&
                (i_fwd_dest[i*AW +: AW] == i_addr)) begin
                w_hit       = 1'b1;
                o_value     = i_fwd_data[i*XLEN +: XLEN];
                o_not_ready = !i_fwd_ready[i];
            end
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand stage: holds one instruction, resolves rs/rt through
// the bypass network and stalls while a needed result is still in flight.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int NREG       = NREG_DEF,
    parameter int NFWD       = NFWD_DEF,
    parameter int PAYLOAD_WD = PAYLOAD_WD_DEF,
    localparam int AW        = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_allowin,
    input  logic [PAYLOAD_WD-1:0] in_payload,
    input  logic [AW-1:0]         in_rs,
    input  logic [AW-1:0]         in_rt,
    input  logic [1:0]            in_rd_en,
    input  logic                  flush,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD*AW-1:0]    fwd_dest,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    input  logic [NFWD-1:0]       fwd_ready,
    output logic [AW-1:0]         rf_raddr1,
    output logic [AW-1:0]         rf_raddr2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    output logic                  out_valid,
    input  logic                  out_allowin,
    output logic [PAYLOAD_WD-1:0] out_payload,
    output logic [XLEN-1:0]       out_rs_value,
    output logic [XLEN-1:0]       out_rt_value,
    output logic [31:0]           stall_cnt
);

    logic                  r_valid;
    logic [PAYLOAD_WD-1:0] r_payload;
    logic [AW-1:0]         r_rs;
    logic [AW-1:0]         r_rt;
    logic [1:0]            r_rd_en;
    logic [31:0]           r_stall_cnt;

    logic w_rs_used;
    logic w_rt_used;
    logic w_rs_not_ready;
    logic w_rt_not_ready;
    logic w_ready_go;
    logic w_load;

    // Register 0 is hardwired, so it never participates in bypassing.
    assign w_rs_used  = r_rd_en[RD_EN_RS] && (r_rs != '0);
    assign w_rt_used  = r_rd_en[RD_EN_RT] && (r_rt != '0);
    assign w_ready_go = !(w_rs_not_ready || w_rt_not_ready);

    // Valid/ready: a transfer happens on an edge where valid && allowin.
    // Flush forces allowin high but the offered instruction is dropped.
    assign in_allowin = !r_valid || (w_ready_go && out_allowin) || flush;
    assign out_valid  = r_valid && w_ready_go && !flush;
    assign w_load     = in_valid && in_allowin && !flush;

    assign rf_raddr1   = r_rs;
    assign rf_raddr2   = r_rt;
    assign out_payload = r_payload;
    assign stall_cnt   = r_stall_cnt;

    fwd_select #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_fwd_rs (
        .i_used      (w_rs_used),
        .i_addr      (r_rs),
        .i_fwd_valid (fwd_valid),
        .i_fwd_dest  (fwd_dest),
        .i_fwd_data  (fwd_data),
        .i_fwd_ready (fwd_ready),
        .i_rf_data   (rf_rdata1),
        .o_value     (out_rs_value),
        .o_not_ready (w_rs_not_ready)
    );

    fwd_select #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_fwd_rt (
        .i_used      (w_rt_used),
        .i_addr      (r_rt),
        .i_fwd_valid (fwd_valid),
        .i_fwd_dest  (fwd_dest),
        .i_fwd_data  (fwd_data),
        .i_fwd_ready (fwd_ready),
        .i_rf_data   (rf_rdata2),
        .o_value     (out_rt_value),
        .o_not_ready (w_rt_not_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (in_allowin) begin
                r_valid <= in_valid;
            end
            if (r_valid && !w_ready_go && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    // Instruction fields are only meaningful while r_valid is set.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_payload <= in_payload;
            r_rs      <= in_rs;
            r_rt      <= in_rt;
            r_rd_en   <= in_rd_en;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: hand-computed expectations for
// bypass priority, hazard stalls, flush, backpressure and reset.
module tb_id_operand_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_allowin;
    logic [63:0] in_payload;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [1:0]  in_rd_en;
    logic        flush;
    logic [2:0]  fwd_valid;
    logic [14:0] fwd_dest;
    logic [95:0] fwd_data;
    logic [2:0]  fwd_ready;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        out_valid;
    logic        out_allowin;
    logic [63:0] out_payload;
    logic [31:0] out_rs_value;
    logic [31:0] out_rt_value;
    logic [31:0] stall_cnt;

    int checks;
    int failures;

    localparam logic [63:0] P1 = 64'h1111_0000_0000_0001;
    localparam logic [63:0] P2 = 64'h2222_0000_0000_0002;
    localparam logic [63:0] P3 = 64'h3333_0000_0000_0003;
    localparam logic [63:0] P4 = 64'h4444_0000_0000_0004;
    localparam logic [63:0] P5 = 64'h5555_0000_0000_0005;
    localparam logic [63:0] PX = 64'hDEAD_BEEF_0000_000A;
    localparam logic [63:0] PY = 64'hCAFE_F00D_0000_000B;
    localparam logic [63:0] PZ = 64'h0BAD_0BAD_0000_000C;
    localparam logic [63:0] P6 = 64'h6666_0000_0000_0006;

    id_operand_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_allowin   (in_allowin),
        .in_payload   (in_payload),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd_en     (in_rd_en),
        .flush        (flush),
        .fwd_valid    (fwd_valid),
        .fwd_dest     (fwd_dest),
        .fwd_data     (fwd_data),
        .fwd_ready    (fwd_ready),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .out_valid    (out_valid),
        .out_allowin  (out_allowin),
        .out_payload  (out_payload),
        .out_rs_value (out_rs_value),
        .out_rt_value (out_rt_value),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow a
    // further 1 unit of settling, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fwd(input logic [2:0] v, input logic [2:0] rdy,
                           input logic [4:0] d2, input logic [4:0] d1, input logic [4:0] d0,
                           input logic [31:0] x2, input logic [31:0] x1, input logic [31:0] x0);
        fwd_valid = v;
        fwd_ready = rdy;
        fwd_dest  = {d2, d1, d0};
        fwd_data  = {x2, x1, x0};
    endtask

    task automatic load(input logic [63:0] p, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] en);
        in_valid   = 1'b1;
        in_payload = p;
        in_rs      = rs;
        in_rt      = rt;
        in_rd_en   = en;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_payload  = '0;
        in_rs       = '0;
        in_rt       = '0;
        in_rd_en    = '0;
        flush       = 1'b0;
        out_allowin = 1'b1;
        rf_rdata1   = '0;
        rf_rdata2   = '0;
        set_fwd(3'b000, 3'b111, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_allowin", 64'(in_allowin), 64'd1);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Plain regfile operand; rt not enabled so its bypass hit is ignored
        set_fwd(3'b010, 3'b111, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);
        rf_rdata1 = 32'h1234;
        rf_rdata2 = 32'hBEEF;
        load(P1, 5'd5, 5'd9, 2'b01);
        settle();
        check("a_out_valid", 64'(out_valid), 64'd1);
        check("a_rs_value", 64'(out_rs_value), 64'h1234);
        check("a_rt_unused", 64'(out_rt_value), 64'hBEEF);
        check("a_raddr1", 64'(rf_raddr1), 64'd5);
        check("a_raddr2", 64'(rf_raddr2), 64'd9);
        check("a_payload", out_payload, P1);
        check("a_in_allowin", 64'(in_allowin), 64'd1);
        tick();
        settle();
        check("a_drain_valid", 64'(out_valid), 64'd0);

        // Bypass priority, held under backpressure
        out_allowin = 1'b0;
        set_fwd(3'b101, 3'b111, 5'd7, 5'd0, 5'd7, 32'hC, 32'h0, 32'hA);
        load(P2, 5'd7, 5'd0, 2'b01);
        settle();
        check("b_youngest", 64'(out_rs_value), 64'hA);
        check("b_out_valid", 64'(out_valid), 64'd1);
        set_fwd(3'b100, 3'b111, 5'd7, 5'd0, 5'd7, 32'hC, 32'h0, 32'hA);
        settle();
        check("b_older", 64'(out_rs_value), 64'hC);
        set_fwd(3'b101, 3'b110, 5'd7, 5'd0, 5'd7, 32'hC, 32'h0, 32'hA);
        settle();
        check("b_young_not_ready", 64'(out_valid), 64'd0);
        check("b_stall_allowin", 64'(in_allowin), 64'd0);
        set_fwd(3'b101, 3'b011, 5'd7, 5'd0, 5'd7, 32'hC, 32'h0, 32'hA);
        settle();
        check("b_older_not_ready_ignored", 64'(out_valid), 64'd1);
        check("b_older_nr_value", 64'(out_rs_value), 64'hA);
        set_fwd(3'b000, 3'b111, 5'd7, 5'd0, 5'd7, 32'hC, 32'h0, 32'hA);
        settle();
        check("b_no_fwd", 64'(out_rs_value), 64'h1234);
        out_allowin = 1'b1;
        settle();
        check("b_allowin", 64'(in_allowin), 64'd1);
        tick();
        settle();
        check("b_drain_valid", 64'(out_valid), 64'd0);
        check("b_stall_cnt", 64'(stall_cnt), 64'd0);

        // Two-cycle hazard on rt
        set_fwd(3'b010, 3'b101, 5'd0, 5'd3, 5'd0, 32'h0, 32'h55, 32'h0);
        load(P3, 5'd0, 5'd3, 2'b10);
        settle();
        check("c_stall1_valid", 64'(out_valid), 64'd0);
        tick();
        settle();
        check("c_stall2_valid", 64'(out_valid), 64'd0);
        check("c_stall2_cnt", 64'(stall_cnt), 64'd1);
        tick();
        fwd_ready = 3'b111;
        settle();
        check("c_go_valid", 64'(out_valid), 64'd1);
        check("c_go_rt_value", 64'(out_rt_value), 64'h55);
        check("c_go_stall_cnt", 64'(stall_cnt), 64'd2);
        tick();
        settle();
        check("c_drain_valid", 64'(out_valid), 64'd0);
        check("c_drain_cnt", 64'(stall_cnt), 64'd2);

        // Register 0 never bypasses nor stalls
        set_fwd(3'b001, 3'b111, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF);
        rf_rdata1 = 32'h7777;
        load(P4, 5'd0, 5'd0, 2'b01);
        settle();
        check("d_r0_value", 64'(out_rs_value), 64'h7777);
        check("d_r0_valid", 64'(out_valid), 64'd1);
        fwd_ready = 3'b110;
        settle();
        check("d_r0_no_stall", 64'(out_valid), 64'd1);
        fwd_ready = 3'b111;
        tick();
        settle();
        check("d_stall_cnt", 64'(stall_cnt), 64'd2);

        // Flush of a stalled instruction drops the simultaneous load
        set_fwd(3'b001, 3'b110, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h44);
        load(P5, 5'd4, 5'd0, 2'b01);
        settle();
        check("e_stalled_valid", 64'(out_valid), 64'd0);
        tick();
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_payload = PX;
        in_rs      = 5'd6;
        in_rd_en   = 2'b01;
        settle();
        check("e_flush_allowin", 64'(in_allowin), 64'd1);
        check("e_flush_out_valid", 64'(out_valid), 64'd0);
        check("e_flush_cnt", 64'(stall_cnt), 64'd3);
        tick();
        flush = 1'b0;
        set_fwd(3'b000, 3'b111, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        in_payload = PY;
        rf_rdata1  = 32'h6666;
        settle();
        check("e_not_loaded", 64'(out_valid), 64'd0);
        check("e_allowin", 64'(in_allowin), 64'd1);
        check("e_cnt_hold", 64'(stall_cnt), 64'd3);
        out_allowin = 1'b0;
        tick();
        in_payload = PZ;
        settle();
        check("e_accept_valid", 64'(out_valid), 64'd1);
        check("e_accept_payload", out_payload, PY);
        check("e_accept_value", 64'(out_rs_value), 64'h6666);

        // Downstream backpressure for three cycles
        for (int i = 0; i < 3; i++) begin
            check("f_bp_valid", 64'(out_valid), 64'd1);
            check("f_bp_payload", out_payload, PY);
            check("f_bp_allowin", 64'(in_allowin), 64'd0);
            check("f_bp_cnt", 64'(stall_cnt), 64'd3);
            tick();
            settle();
        end
        flush = 1'b1;
        settle();
        check("f_flush_out_valid", 64'(out_valid), 64'd0);
        check("f_flush_allowin", 64'(in_allowin), 64'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        check("f_after_flush", 64'(out_valid), 64'd0);

        // Reset wins over a simultaneous load and clears the counter
        load(P6, 5'd0, 5'd0, 2'b00);
        settle();
        check("g_loaded", 64'(out_valid), 64'd1);
        reset    = 1'b1;
        in_valid = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        settle();
        check("g_rst_valid", 64'(out_valid), 64'd0);
        check("g_rst_cnt", 64'(stall_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
